// File: rtl/evaluador_ganador.sv
// -----------------------------------------------------------------------------
// evaluador_ganador
//   Sequential tic-tac-toe result evaluator. On a start request it captures the
//   board and then scans the 8 winning lines, one per clock. The scan stops at
//   the first winning line. If no line wins, it checks whether the board is full
//   (a draw). Results are registered and held for the VGA text selector until
//   the next accepted start or reset.
//
//   Optional build macro: WIN_LINE_EN adds the `linea` output, which carries
//   the index of the winning line.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   start    in   evaluation request (sampled only while idle)
//   tablero  in   [17:0] board, cell i = row*3+col at bits [2i+1:2i]
//                 (0 = empty, 1/2 = player codes, 3 = invalid -> empty)
//   busy     out  high while scanning lines or checking for a full board
//   done     out  one-cycle pulse when results update
//   gano     out  a player completed a line
//   empate   out  board full with no winner
//   ganador  out  [1:0] 0 = none, 1 = player 1, 2 = player 2
//   linea    out  [2:0] winning line index (WIN_LINE_EN only)
// -----------------------------------------------------------------------------
module evaluador_ganador #(
  parameter logic [1:0] PLAYER1_CODE = 2'd1,
  parameter logic [1:0] PLAYER2_CODE = 2'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [17:0] tablero,
  output logic        busy,
  output logic        done,
  output logic        gano,
  output logic        empate,
  output logic [1:0]  ganador
`ifdef WIN_LINE_EN
  ,
  output logic [2:0]  linea
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_FULLCHK, S_DONE} state_t;

  // Cell indices of each line, 4 bits per cell, 12 bits per line, line 0 in
  // the LSBs: rows, then columns, then diagonal and anti-diagonal.
  localparam logic [95:0] LINE_CELLS = {
    4'd6, 4'd4, 4'd2,   // 7: anti-diagonal
    4'd8, 4'd4, 4'd0,   // 6: diagonal
    4'd8, 4'd5, 4'd2,   // 5: col2
    4'd7, 4'd4, 4'd1,   // 4: col1
    4'd6, 4'd3, 4'd0,   // 3: col0
    4'd8, 4'd7, 4'd6,   // 2: row2
    4'd5, 4'd4, 4'd3,   // 1: row1
    4'd2, 4'd1, 4'd0    // 0: row0
  };

  state_t      r_state;
  state_t      w_state_next;
  logic [17:0] r_tablero;
  logic [2:0]  r_idx;
  logic        r_gano;
  logic        r_empate;
  logic [1:0]  r_ganador;
`ifdef WIN_LINE_EN
  logic [2:0]  r_linea;
`endif

  logic [1:0]  w_cell [9];
  logic [8:0]  w_occupied;
  logic [7:0]  w_win_p1;
  logic [7:0]  w_win_p2;
  logic        w_line_p1;
  logic        w_line_p2;
  logic        w_line_win;
  logic        w_full;

  // Unpack the captured board. Code 3 matches neither player, so it counts as
  // empty for both the line check and the full-board check.
  for (genvar gi = 0; gi < 9; gi++) begin : g_cell
    assign w_cell[gi]     = r_tablero[2*gi +: 2];
    assign w_occupied[gi] = (w_cell[gi] == PLAYER1_CODE) ||
                            (w_cell[gi] == PLAYER2_CODE);
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_line
    localparam int C0 = int'(LINE_CELLS[gi*12 + 0 +: 4]);
    localparam int C1 = int'(LINE_CELLS[gi*12 + 4 +: 4]);
    localparam int C2 = int'(LINE_CELLS[gi*12 + 8 +: 4]);
    assign w_win_p1[gi] = (w_cell[C0] == PLAYER1_CODE) &&
                          (w_cell[C1] == PLAYER1_CODE) &&
                          (w_cell[C2] == PLAYER1_CODE);
    assign w_win_p2[gi] = (w_cell[C0] == PLAYER2_CODE) &&
                          (w_cell[C1] == PLAYER2_CODE) &&
                          (w_cell[C2] == PLAYER2_CODE);
  end

  // Only the line selected by the scan index is considered each cycle.
  assign w_line_p1  = w_win_p1[r_idx];
  assign w_line_p2  = w_win_p2[r_idx];
  assign w_line_win = w_line_p1 || w_line_p2;
  assign w_full     = &w_occupied;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_CHECK;
      S_CHECK: begin
        if (w_line_win)          w_state_next = S_DONE;
        else if (r_idx == 3'd7)  w_state_next = S_FULLCHK;
      end
      S_FULLCHK: w_state_next = S_DONE;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tablero <= '0;
      r_idx     <= '0;
      r_gano    <= 1'b0;
      r_empate  <= 1'b0;
      r_ganador <= 2'd0;
`ifdef WIN_LINE_EN
      r_linea   <= 3'd0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tablero <= tablero;
            r_idx     <= 3'd0;
            r_gano    <= 1'b0;
            r_empate  <= 1'b0;
            r_ganador <= 2'd0;
`ifdef WIN_LINE_EN
            r_linea   <= 3'd0;
`endif
          end
        end
        S_CHECK: begin
          if (w_line_win) begin
            r_gano    <= 1'b1;
            // Player 1 takes precedence only if both codes were configured equal.
            r_ganador <= w_line_p1 ? 2'd1 : 2'd2;
`ifdef WIN_LINE_EN
            r_linea   <= r_idx;
`endif
          end else if (r_idx != 3'd7) begin
            r_idx <= r_idx + 3'd1;
          end
        end
        S_FULLCHK: begin
          r_empate  <= w_full;
          r_gano    <= 1'b0;
          r_ganador <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode the state register directly, so they remain free of
  // any combinational path from the inputs.
  assign busy    = (r_state == S_CHECK) || (r_state == S_FULLCHK);
  assign done    = (r_state == S_DONE);
  assign gano    = r_gano;
  assign empate  = r_empate;
  assign ganador = r_ganador;
`ifdef WIN_LINE_EN
  assign linea   = r_linea;
`endif

endmodule

// File: tb/tb_evaluador_ganador.sv
// -----------------------------------------------------------------------------
// tb_evaluador_ganador
//   Scoreboard bench for evaluador_ganador. Each accepted start pushes the
//   expected result and completion cycle. A negedge monitor pops the entry on
//   every done pulse and compares it.
// -----------------------------------------------------------------------------
module tb_evaluador_ganador;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [17:0] tablero = '0;
  logic        busy, done, gano, empate;
  logic [1:0]  ganador;
`ifdef WIN_LINE_EN
  logic [2:0]  linea;
`endif

  evaluador_ganador dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tablero (tablero),
    .busy    (busy),
    .done    (done),
    .gano    (gano),
    .empate  (empate),
    .ganador (ganador)
`ifdef WIN_LINE_EN
    ,
    .linea   (linea)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       gano;
    logic       empate;
    logic [1:0] ganador;
    logic [2:0] linea;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: one line per completed evaluation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("gano", gano, e.gano);
        chk("empate", empate, e.empate);
        chk("ganador", ganador, e.ganador);
        chk("done_cycle", cyc, e.cyc);
        chk("gano_empate_excl", gano & empate, 0);
`ifdef WIN_LINE_EN
        if (e.gano) chk("linea", linea, e.linea);
`endif
        $display("done @%0d gano=%0d empate=%0d ganador=%0d", cyc, gano, empate, ganador);
      end
    end
  end

  // Issue one evaluation and wait for it to retire. lat is the done cycle
  // relative to the sampling edge T. With glitch set, start is pulsed again
  // with a different board mid-scan, and the board is left changed.
  task automatic eval(input logic [17:0] board, input logic g, input logic e,
                      input logic [1:0] w, input logic [2:0] l, input int lat,
                      input bit glitch);
    exp_t x;
    int   n;
    int   busy_cnt;
    x.gano = g; x.empate = e; x.ganador = w; x.linea = l; x.cyc = cyc + lat;
    sb.push_back(x);
    start   = 1'b1;
    tablero = board;
    tick();
    start = 1'b0;
    // Cycle T+1: previous results must already be cleared.
    chk("cleared_gano", gano, 0);
    chk("cleared_empate", empate, 0);
    chk("cleared_ganador", ganador, 0);
    n = 0;
    busy_cnt = 0;
    while (sb.size() != 0 && n < 20) begin
      if (busy) busy_cnt++;
      if (glitch && n == 2) begin
        start   = 1'b1;
        tablero = 18'h2A000;   // row2 all O, would win if it were taken
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      chk("timeout", 0, 1);
      sb.delete();
    end
    chk("busy_cycles", busy_cnt, lat - 1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_gano", gano, 0);
    chk("rst_empate", empate, 0);
    chk("rst_ganador", ganador, 0);
`ifdef WIN_LINE_EN
    chk("rst_linea", linea, 0);
`endif
    rst = 1'b0;
    tick();

    //   board       gano emp win lin lat glitch
    eval(18'h00015, 1, 0, 2'd1, 3'd0, 2,  0);  // row0 X
    eval(18'h20820, 1, 0, 2'd2, 3'd5, 7,  0);  // col2 O
    eval(18'h16A59, 0, 1, 2'd0, 3'd0, 10, 0);  // full board, draw
    eval(18'h00015, 1, 0, 2'd1, 3'd0, 2,  0);  // stale draw cleared
    eval(18'h00000, 0, 0, 2'd0, 3'd0, 10, 0);  // empty board
    eval(18'h00015, 1, 0, 2'd1, 3'd0, 2,  0);
    eval(18'h16A7F, 0, 0, 2'd0, 3'd0, 10, 0);  // code 3 in row0, not full
    eval(18'h00540, 1, 0, 2'd1, 3'd1, 3,  0);  // row1 X
    eval(18'h20202, 1, 0, 2'd2, 3'd6, 8,  0);  // diagonal O
    eval(18'h01110, 1, 0, 2'd1, 3'd7, 9,  0);  // anti-diagonal X
    eval(18'h0002A, 1, 0, 2'd2, 3'd0, 2,  0);  // row0 O
    eval(18'h16A59, 0, 1, 2'd0, 3'd0, 10, 1);  // start/board change mid-scan ignored
    repeat (12) tick();                        // any queued start would show up here

    // Reset in cycle T+4 of a scan: no done, outputs zero, back to idle.
    start   = 1'b1;
    tablero = 18'h16A59;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_gano", gano, 0);
    chk("midrst_empate", empate, 0);
    chk("midrst_ganador", ganador, 0);
    rst = 1'b0;
    repeat (12) tick();
    eval(18'h00015, 1, 0, 2'd1, 3'd0, 2, 0);   // idle again, accepts start

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
